// File: rtl/dmem_pkg.sv
// dmem_pkg
//   Shared types and constants for the data-memory arbiter slice.
//   - DADDR_W / DDATA_W : memory address and data widths.
//   - CNT_W / CNT_MAX   : width and saturation value of the burst counter.
//   - dmem_req_t        : one requester's access (rw, addr, wdata).
//   - dmem_src_t        : requester identity (core = 0, loader = 1).
//   - dmem_arb_state_t  : the arbiter's registered state, also driven out
//                         on the debug port of dmem_arbiter.
package dmem_pkg;

    localparam int DADDR_W = 10;
    localparam int DDATA_W = 32;
    localparam int CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

    typedef struct packed {
        logic               rw;     // 1 = write, 0 = read
        logic [DADDR_W-1:0] addr;
        logic [DDATA_W-1:0] wdata;
    } dmem_req_t;

    typedef enum logic {
        REQ_CORE   = 1'b0,
        REQ_LOADER = 1'b1
    } dmem_src_t;

    typedef struct packed {
        dmem_src_t          owner;      // last requester granted
        logic [CNT_W-1:0]   owner_cnt;  // consecutive grants to owner
        logic               rd_pend;    // read issued last cycle
        dmem_src_t          rd_tag;     // who issued that read
        logic               cold;       // no grant since reset
    } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick
//   Combinational grant decision for the two-port data-memory arbiter.
//   Ports:
//     req0, req1 : in  request lines of core (0) and loader (1)
//     owner      : in  requester that currently holds the burst
//     owner_cnt  : in  consecutive grants already given to owner
//     gnt        : out one-hot grant vector (bit K = requester K), or 0
module dmem_arb_pick
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic             req0,
    input  logic             req1,
    input  dmem_src_t        owner,
    input  logic [CNT_W-1:0] owner_cnt,
    output logic [1:0]       gnt
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    always_comb begin
        gnt = 2'b00;
        if (req0 && req1) begin
            // Owner keeps the path until it has used up its burst allowance.
            if (owner_cnt < BURST_LIM) begin
                gnt = (owner == REQ_CORE) ? 2'b01 : 2'b10;
            end else begin
                gnt = (owner == REQ_CORE) ? 2'b10 : 2'b01;
            end
        end else if (req0) begin
            gnt = 2'b01;
        end else if (req1) begin
            gnt = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single data-memory path between the core data port
//   (requester 0) and the program/data loader (requester 1). One access per
//   cycle; grants are combinational; read data comes back one cycle after
//   the read strobe and is steered to the requester that issued the read.
//   Consecutive grants under contention are bounded by MAX_BURST (1..15).
//
//   Handshake: a requester holds reqK/rwK/addrK/wdataK stable until gntK is
//   seen high in the same cycle; that cycle is the access. Dropping reqK
//   before a grant abandons the request. rvalidK is a one-cycle pulse with
//   no back-pressure; rdataK is 0 whenever rvalidK is low.
//
//   Ports:
//     CLK, RESET_N           system clock, asynchronous active-low reset
//     req*/rw*/addr*/wdata*  requester access inputs
//     gnt0/gnt1              grant, combinational
//     rvalid*/rdata*         read response per requester
//     daddr/d_rw/ddata_w     access to the memory controller (0 when idle)
//     d_req                  access strobe, high exactly when a grant is
//     ddata_r                read data from memory, one cycle after d_req
//     dbg_state              registered arbiter state
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 req0,
    input  logic                 rw0,
    input  logic [DADDR_W-1:0]   addr0,
    input  logic [DDATA_W-1:0]   wdata0,
    input  logic                 req1,
    input  logic                 rw1,
    input  logic [DADDR_W-1:0]   addr1,
    input  logic [DDATA_W-1:0]   wdata1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 rvalid0,
    output logic                 rvalid1,
    output logic [DDATA_W-1:0]   rdata0,
    output logic [DDATA_W-1:0]   rdata1,
    output logic [DADDR_W-1:0]   daddr,
    output logic                 d_rw,
    output logic [DDATA_W-1:0]   ddata_w,
    output logic                 d_req,
    input  logic [DDATA_W-1:0]   ddata_r,
    output dmem_arb_state_t      dbg_state
);

    dmem_arb_state_t state_q;
    dmem_arb_state_t state_d;
    dmem_req_t       req0_s;
    dmem_req_t       req1_s;
    dmem_req_t       sel;
    dmem_src_t       gnt_src;
    dmem_src_t       pick_owner;
    logic [1:0]      gnt;

    assign req0_s = '{rw: rw0, addr: addr0, wdata: wdata0};
    assign req1_s = '{rw: rw1, addr: addr1, wdata: wdata1};

    // The reset owner (loader) marks the loader as last served, so the core
    // must win the first contention after reset. Until the first grant the
    // core is presented as owner to the picker.
    assign pick_owner = state_q.cold ? REQ_CORE : state_q.owner;

    dmem_arb_pick #(
        .MAX_BURST (MAX_BURST)
    ) u_pick (
        .req0      (req0),
        .req1      (req1),
        .owner     (pick_owner),
        .owner_cnt (state_q.owner_cnt),
        .gnt       (gnt)
    );

    assign gnt_src = dmem_src_t'(gnt[1]);
    assign sel     = gnt[1] ? req1_s : req0_s;

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= '{owner: REQ_LOADER, owner_cnt: '0, rd_pend: 1'b0,
                         rd_tag: REQ_CORE, cold: 1'b1};
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (gnt != 2'b00) begin
            state_d.cold = 1'b0;
            if (gnt_src == state_q.owner) begin
                if (state_q.owner_cnt != CNT_MAX) begin
                    state_d.owner_cnt = state_q.owner_cnt + 4'd1;
                end
            end else begin
                state_d.owner     = gnt_src;
                state_d.owner_cnt = 4'd1;
            end
            state_d.rd_pend = !sel.rw;
            if (!sel.rw) begin
                state_d.rd_tag = gnt_src;
            end
        end else begin
            state_d.owner_cnt = '0;
            state_d.rd_pend   = 1'b0;
        end
    end

    // Output logic
    always_comb begin
        gnt0    = gnt[0];
        gnt1    = gnt[1];
        d_req   = gnt != 2'b00;
        daddr   = '0;
        d_rw    = 1'b0;
        ddata_w = '0;
        if (d_req) begin
            daddr   = sel.addr;
            d_rw    = sel.rw;
            ddata_w = sel.wdata;
        end
        rvalid0 = state_q.rd_pend && (state_q.rd_tag == REQ_CORE);
        rvalid1 = state_q.rd_pend && (state_q.rd_tag == REQ_LOADER);
        rdata0  = rvalid0 ? ddata_r : '0;
        rdata1  = rvalid1 ? ddata_r : '0;
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic        req0 = 0, rw0 = 0, req1 = 0, rw1 = 0;
    logic [9:0]  addr0 = '0, addr1 = '0;
    logic [31:0] wdata0 = '0, wdata1 = '0, ddata_r = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, d_rw, d_req;
    logic [31:0] rdata0, rdata1, ddata_w;
    logic [9:0]  daddr;
    dmem_arb_state_t dbg_state;

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    dmem_arbiter #(.MAX_BURST(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .req0(req0), .rw0(rw0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .rw1(rw1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
        .daddr(daddr), .d_rw(d_rw), .ddata_w(ddata_w), .d_req(d_req),
        .ddata_r(ddata_r), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  gnt;
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct packed {
        int unsigned cyc;
        logic [1:0]  rv;
        logic [31:0] rdata1;
        logic [31:0] rdata0;
    } rd_exp_t;

    mem_exp_t mem_q[$];
    rd_exp_t  rd_q[$];
    mem_exp_t me;
    rd_exp_t  re;
    int n_cmp = 0;
    int n_err = 0;

    function automatic void check(input string name, input logic [95:0] act,
                                  input logic [95:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
        end
    endfunction

    // Monitor: every cycle, the memory side and the response side are
    // compared against the entry stamped for this cycle, or against idle.
    always @(negedge CLK) begin
        if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
            me = mem_q.pop_front();
            check("mem_access", 96'({d_req, gnt1, gnt0, d_rw, daddr, ddata_w}),
                  96'({1'b1, me.gnt, me.rw, me.addr, me.wdata}));
        end else begin
            check("mem_idle", 96'({d_req, gnt1, gnt0, d_rw, daddr, ddata_w}), 96'(0));
        end
        if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
            re = rd_q.pop_front();
            check("rd_resp", 96'({rvalid1, rvalid0, rdata1, rdata0}),
                  96'({re.rv, re.rdata1, re.rdata0}));
        end else begin
            check("rd_idle", 96'({rvalid1, rvalid0, rdata1, rdata0}), 96'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
        ddata_r = $urandom;
    endtask

    task automatic set0(input logic r, input logic rw, input logic [9:0] a,
                        input logic [31:0] w);
        req0 = r; rw0 = rw; addr0 = a; wdata0 = w;
    endtask

    task automatic set1(input logic r, input logic rw, input logic [9:0] a,
                        input logic [31:0] w);
        req1 = r; rw1 = rw; addr1 = a; wdata1 = w;
    endtask

    task automatic exp_mem(input logic [1:0] g, input logic rw, input logic [9:0] a,
                           input logic [31:0] w);
        mem_exp_t e;
        e.cyc = cyc; e.gnt = g; e.rw = rw; e.addr = a; e.wdata = w;
        mem_q.push_back(e);
    endtask

    // Response expected one cycle after the current (grant) cycle.
    task automatic exp_rd(input logic id, input logic [31:0] d);
        rd_exp_t e;
        e.cyc    = cyc + 1;
        e.rv     = id ? 2'b10 : 2'b01;
        e.rdata1 = id ? d : 32'h0;
        e.rdata0 = id ? 32'h0 : d;
        rd_q.push_back(e);
    endtask

    // Contention writes: core to 0x0A0, loader to 0x3A1.
    task automatic exp_grant(input int k);
        if (k == 1) exp_mem(2'b10, 1'b1, 10'h3A1, 32'h1000_0001);
        else        exp_mem(2'b01, 1'b1, 10'h0A0, 32'hC000_0000);
    endtask

    task automatic check_state(input string name, input dmem_src_t owner,
                               input logic [3:0] cnt, input logic pend,
                               input dmem_src_t tag, input logic cold);
        dmem_arb_state_t s;
        s.owner = owner; s.owner_cnt = cnt; s.rd_pend = pend; s.rd_tag = tag; s.cold = cold;
        check(name, 96'(dbg_state), 96'(s));
    endtask

    int seq_a[11] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    int seq_b[5]  = '{0, 0, 0, 0, 1};

    // ---------------- stimulus ----------------
    initial begin
        tick();
        // During reset a lone req0 is still granted combinationally, but
        // the registers stay cleared, so no response follows.
        set0(1, 0, 10'h055, 32'h0);
        exp_mem(2'b01, 1'b0, 10'h055, 32'h0);
        tick();
        set0(0, 0, 10'h0, 32'h0);
        tick();
        RESET_N = 1'b1;
        check_state("reset_state", REQ_LOADER, 4'd0, 1'b0, REQ_CORE, 1'b1);

        // Core read of 0x004, response 0xDEADBEEF next cycle.
        set0(1, 0, 10'h004, 32'h1111_1111);
        exp_mem(2'b01, 1'b0, 10'h004, 32'h1111_1111);
        exp_rd(1'b0, 32'hDEAD_BEEF);
        tick();
        set0(0, 0, 10'h0, 32'h0);
        ddata_r = 32'hDEAD_BEEF;
        tick();

        // Loader write to peripheral space; no response.
        set1(1, 1, 10'h200, 32'h0000_ABCD);
        exp_mem(2'b10, 1'b1, 10'h200, 32'h0000_ABCD);
        tick();
        set1(0, 0, 10'h0, 32'h0);
        tick();

        // Back-to-back reads: core then loader.
        set0(1, 0, 10'h010, 32'h0);
        exp_mem(2'b01, 1'b0, 10'h010, 32'h0);
        exp_rd(1'b0, 32'hA5A5_0001);
        tick();
        set0(0, 0, 10'h0, 32'h0);
        set1(1, 0, 10'h201, 32'h0);
        ddata_r = 32'hA5A5_0001;
        exp_mem(2'b10, 1'b0, 10'h201, 32'h0);
        exp_rd(1'b1, 32'h0000_BEEF);
        tick();
        set1(0, 0, 10'h0, 32'h0);
        ddata_r = 32'h0000_BEEF;
        tick();

        // Reset in the cycle after a core read grant: response is dropped.
        set0(1, 0, 10'h030, 32'h0);
        exp_mem(2'b01, 1'b0, 10'h030, 32'h0);
        tick();
        set0(0, 0, 10'h0, 32'h0);
        ddata_r = 32'hBAD0_BAD0;
        RESET_N = 1'b0;
        tick();
        tick();
        RESET_N = 1'b1;
        check_state("reset_mid_read", REQ_LOADER, 4'd0, 1'b0, REQ_CORE, 1'b1);

        // Continuous contention from reset: 0,0,0,0,1,1,1,1,0,0,0.
        set0(1, 1, 10'h0A0, 32'hC000_0000);
        set1(1, 1, 10'h3A1, 32'h1000_0001);
        for (int i = 0; i < 11; i++) begin
            exp_grant(seq_a[i]);
            tick();
        end
        check_state("burst_cnt3", REQ_CORE, 4'd3, 1'b0, REQ_CORE, 1'b0);

        // One idle cycle clears the count; core then gets four more.
        set0(0, 1, 10'h0A0, 32'hC000_0000);
        set1(0, 1, 10'h3A1, 32'h1000_0001);
        tick();
        check_state("idle_clear", REQ_CORE, 4'd0, 1'b0, REQ_CORE, 1'b0);
        set0(1, 1, 10'h0A0, 32'hC000_0000);
        set1(1, 1, 10'h3A1, 32'h1000_0001);
        for (int i = 0; i < 5; i++) begin
            exp_grant(seq_b[i]);
            tick();
        end
        set0(0, 0, 10'h0, 32'h0);
        set1(0, 0, 10'h0, 32'h0);
        tick();
        tick();

        check("queues_drained", 96'({mem_q.size(), rd_q.size()}), 96'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data-memory path between the core data port (requester 0) and the program/data loader (requester 1). It sits directly upstream of the existing data-memory controller that splits the 10-bit address space into the 32-bit RAM (daddr[9]=0) and the 16-bit peripheral space (daddr[9]=1). Accepts at most one access per cycle, routes one-cycle-latency read data back to the requester that issued the read, and bounds consecutive grants so neither side starves.

## Interface
- MAX_BURST, 4: consecutive grants the current owner may keep while the other side is waiting; legal range 1..15.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request, held until granted.
- rw0 / rw1  in  1  1 = write, 0 = read (same meaning as d_rw).
- addr0 / addr1  in  10  word address.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  request accepted this cycle (combinational).
- rvalid0 / rvalid1  out  1  read data valid for that requester.
- rdata0 / rdata1  out  32  read data; 0 when the matching rvalid is low.
- daddr  out  10  address to the memory controller.
- d_rw  out  1  read/write to the memory controller.
- ddata_w  out  32  write data to the memory controller.
- d_req  out  1  access strobe; 1 exactly when one gnt is high.
- ddata_r  in  32  read data from memory, valid one cycle after the read strobe.

## Operation
- Grant rule, evaluated every cycle:
  - neither req high: no grant; d_req=0; daddr, d_rw, ddata_w = 0.
  - only reqK high: grant K.
  - both high: grant owner if owner_cnt < MAX_BURST, otherwise grant the other requester.
- State: owner (1 bit, the last requester granted), owner_cnt (4 bits), rd_pend (1 bit), rd_tag (1 bit).
- On a grant to K: if K == owner, owner_cnt saturates at 15 while incrementing; otherwise owner = K and owner_cnt = 1.
- Cycle with no grant: owner_cnt = 0 and owner is unchanged.
- Memory-side outputs are a mux of the granted requester's rw/addr/wdata in the same cycle as its gnt.
- A read grant sets rd_pend=1 and rd_tag=K for the next cycle. A write grant or no grant sets rd_pend=0.
- Response decode:
  - rvalidK = rd_pend && rd_tag==K.
  - rdataK = ddata_r when rvalidK is high, otherwise 0.
- Writes produce no response.
- The block does not decode daddr[9]; the downstream controller handles the RAM/peripheral split. Reads from the 16-bit space return whatever ddata_r carries.

## Timing
- Reset values:
  - gnt0/1 follow req with reset state, so req0 alone is granted during reset.
  - rvalid0/1 = 0, rdata0/1 = 0.
  - owner = 1, so requester 0 wins the first contention.
  - owner_cnt = 0, rd_pend = 0, rd_tag = 0.
- Grant is combinational in cycle T. A requester sees gnt in T and may present a new request in T+1, giving one access per cycle back-to-back.
- Read latency: grant in T, rvalidK and rdataK in T+1. A read and a new grant overlap freely in T+1.
- Requesters hold req/rw/addr/wdata stable until gnt. Dropping req before gnt is allowed and means abandon; no state changes.
- Simultaneous requests with owner_cnt == MAX_BURST-1: the owner gets one more grant, then the grant switches on the following contended cycle.
- MAX_BURST=1 gives strict alternation under continuous contention.
- Reset asserted mid-read: the pending rvalid is dropped and never delivered. No grant is issued while RESET_N is low except the combinational path noted above. The memory sees at most the access in flight.

## Structure
- Shared package dmem_pkg:
  - DADDR_W=10, DDATA_W=32.
  - typedef dmem_req_t {rw, addr, wdata}.
  - typedef enum logic {REQ_CORE=0, REQ_LOADER=1} dmem_src_t.
- One combinational sub-module, dmem_arb_pick: inputs req0, req1, owner, owner_cnt; outputs grant vector. The parent holds all registers and the data muxes.

## Test plan
- Reset, then req0 read at addr 0x004 with ddata_r=0xDEADBEEF in the next cycle -> gnt0 in T, daddr=0x004, d_rw=0; rvalid0=1 and rdata0=0xDEADBEEF in T+1; rvalid1=0.
- Both req held high continuously, MAX_BURST=4 -> first grant to requester 0, then grant sequence 0,0,0,0,1,1,1,1,0…
- req1 write to 0x200 with wdata 0x0000ABCD -> d_req=1, d_rw=1, daddr=0x200, ddata_w=0x0000ABCD; no rvalid in the next cycle.
- Read by requester 0 in T, read by requester 1 in T+1 -> rvalid0 in T+1, rvalid1 in T+2; each rdata carries its own ddata_r value and the other rdata stays 0.
- Idle cycle inserted after three owner-0 grants under contention -> owner_cnt clears; the next contended cycle grants 0 for four more cycles.
- RESET_N pulled low in the cycle after a read grant -> rvalid0 stays 0; after release owner=1, owner_cnt=0, and the next contention grants requester 0.
